ysyx_23060061_lsu_hs: RTL and testbench
=======================================

Name: ysyx_23060061_lsu_hs

Overview:
Multi-cycle load/store unit with valid/ready handshakes on all three sides: EXU in, WBU out, memory request/response. Successor to the single-cycle combinational LSU. Adds:
- parametrised data width (32/64)
- an external memory port with arbitrary latency
- misalignment and illegal-op detection
- a response timeout watchdog
Sits between id_ex_wb and wbu in the multi-cycle core.

Parameters:
DW, 32, data width; legal values 32 or 64; 64 enables LD/LWU/SD.
AW, 32, address width.
TIMEOUT, 255, max cycles in WAIT before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EXU request valid
in_ready  out  1  LSU can accept a request
in_we  in  1  1=store, 0=load
in_ext  in  3  RISC-V funct3 of load/store
in_addr  in  AW  effective address
in_wdata  in  DW  store data (unaligned, LSB-justified)
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts result
out_rdata  out  DW  extended load data (0 for stores and errors)
out_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  write request
mem_req_addr  out  AW  address aligned down to DW/8 bytes
mem_req_wdata  out  DW  lane-shifted store data
mem_req_wmask  out  DW/8  byte-lane write mask
mem_resp_valid  in  1  read data / write ack valid
mem_resp_rdata  in  DW  full-width read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset values: state IDLE; in_ready=1; out_valid=0; mem_req_valid=0; out_rdata=0; out_err=00; all captured registers 0.
- in_ready=1 only in IDLE. A handshake (in_valid&in_ready) captures we, ext, addr and wdata.
- Legality: loads 000,001,010,100,101; stores 000,001,010. With DW=64 also load 011,110 and store 011. Anything else is illegal.
- Alignment: byte any; half addr[0]=0; word addr[1:0]=0; double addr[2:0]=0.
- IDLE, on handshake: illegal -> RESP with err=10; else misaligned -> RESP with err=01; else -> REQ. Illegal takes priority over misaligned. Error cases issue no memory request.
- REQ: mem_req_valid=1, with payload held stable until mem_req_ready. On mem_req_ready -> WAIT, watchdog counter cleared.
- WAIT:
  - mem_resp_valid -> RESP, err=00. Load data is shifted right by addr[log2(DW/8)-1:0]*8, then sign/zero-extended per ext. Stores give rdata=0.
  - counter==TIMEOUT (TIMEOUT>0) with no response -> RESP, err=11, rdata=0.
  - mem_resp_valid in the same cycle as the timeout: response wins.
- RESP: out_valid=1, rdata/err held until out_ready, then -> IDLE. in_ready rises the next cycle; no same-cycle re-accept.
- mem_resp_valid outside WAIT is ignored, including late responses after a timeout. The response is always at least 1 cycle after request acceptance.
- wmask and wdata:
  - wmask = (SB 1, SH 3, SW F, SD FF) << byte offset.
  - wdata = in_wdata shifted left by byte offset*8. Unused lanes are don't-care but driven 0.
  - Loads drive wmask=0.
- Latency: best case with mem_req_ready=1 and a 1-cycle response: handshake at T, req at T+1, resp at T+2, out_valid at T+3.
- Reset mid-operation: aborts immediately to reset values; no out_valid for the in-flight op.
- Widths: the watchdog counter is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package ysyx_23060061_lsu_pkg holds:
  - funct3 constants (F3_B/H/W/D/BU/HU/WU)
  - state enum
  - error code constants
- Sub-module ysyx_23060061_lsu_align (combinational, parametrised by DW) computes:
  - legality and alignment check
  - wmask and wdata lane shift
  - read shift and extension

Test Plan:
1. DW=32, LB at 0x8000_0003, mem returns 0x80FF_FFFF after 3 cycles -> mem_req_addr=0x8000_0000, wmask=0, out_rdata=0xFFFF_FF80, err=00.
2. SH addr 0x8000_0002, wdata 0x0000_BEEF, mem_req_ready low 2 cycles -> req payload stable throughout; wmask=0xC, mem_req_wdata=0xBEEF_0000; one write, out_rdata=0.
3. LW at 0x8000_0006 -> no mem_req_valid, out_valid next cycle, err=01; funct3 111 load -> err=10.
4. TIMEOUT=4, LW with no response -> out_valid 5 cycles after WAIT entry, err=11; late mem_resp_valid then ignored, next op correct.
5. out_ready held low 10 cycles in RESP -> out_valid/out_rdata/out_err stable and in_ready=0; back-to-back loads (LBU 0xFF->0xFF, LHU) complete in order.
6. rst asserted in WAIT -> all outputs return to reset values asynchronously; a response arriving after reset is ignored. DW=64 LD at 0x...8 returns the full 64-bit word.

Source files
------------

// File: rtl/ysyx_23060061_lsu_pkg.sv
// Shared constants and types for the handshaked load/store unit.
// funct3 encodings, error codes, FSM states and the byte-size lane mask helper.
package ysyx_23060061_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StResp
   } lsu_state_e;

   // Bit mask covering the access size encoded in funct3[1:0].
   function automatic logic [63:0] size_mask(input logic [1:0] size);
      logic [63:0] m;
      unique case (size)
         2'd0:    m = 64'h0000_0000_0000_00FF;
         2'd1:    m = 64'h0000_0000_0000_FFFF;
         2'd2:    m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ysyx_23060061_lsu_align.sv
// Combinational lane logic: funct3 legality/alignment of a new request, store lane
// placement, and load extraction with sign/zero extension.
module ysyx_23060061_lsu_align
   import ysyx_23060061_lsu_pkg::*;
#(
   parameter int unsigned DW = 32,
   localparam int unsigned NB = DW / 8,
   localparam int unsigned OW = $clog2(NB)
) (
   input  logic          i_chk_we,
   input  logic [2:0]    i_chk_ext,
   input  logic [OW-1:0] i_chk_off,
   output logic          o_illegal,
   output logic          o_misaligned,
   input  logic          i_we,
   input  logic [2:0]    i_ext,
   input  logic [OW-1:0] i_off,
   input  logic [DW-1:0] i_wdata,
   input  logic [DW-1:0] i_rdata,
   output logic [NB-1:0] o_wmask,
   output logic [DW-1:0] o_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [3:0]    w_amask;
   logic [7:0]    w_bmask;
   logic [15:0]   w_wmask_wide;
   logic [63:0]   w_mask64;
   logic [DW-1:0] w_lane;
   logic [DW-1:0] w_shr;
   logic          w_sign;

   always_comb begin
      o_illegal = 1'b1;
      if (i_chk_we) begin
         unique case (i_chk_ext)
            F3_B, F3_H, F3_W: o_illegal = 1'b0;
            F3_D:             o_illegal = (DW != 64);
            default:          o_illegal = 1'b1;
         endcase
      end else begin
         unique case (i_chk_ext)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: o_illegal = 1'b0;
            F3_D, F3_WU:                    o_illegal = (DW != 64);
            default:                        o_illegal = 1'b1;
         endcase
      end

      unique case (i_chk_ext[1:0])
         2'd0:    w_amask = 4'h0;
         2'd1:    w_amask = 4'h1;
         2'd2:    w_amask = 4'h3;
         default: w_amask = 4'h7;
      endcase
      o_misaligned = |(i_chk_off & w_amask[OW-1:0]);
   end

   always_comb begin
      unique case (i_ext[1:0])
         2'd0:    w_bmask = 8'h01;
         2'd1:    w_bmask = 8'h03;
         2'd2:    w_bmask = 8'h0F;
         default: w_bmask = 8'hFF;
      endcase
      w_mask64     = size_mask(i_ext[1:0]);
      w_lane       = w_mask64[DW-1:0];
      w_wmask_wide = {8'h00, w_bmask} << i_off;
      o_wmask      = i_we ? w_wmask_wide[NB-1:0] : '0;
      // Unused store lanes are cleared before the shift so they drive 0.
      o_wdata      = i_we ? ((i_wdata & w_lane) << {i_off, 3'b000}) : '0;

      w_shr = i_rdata >> {i_off, 3'b000};
      unique case (i_ext[1:0])
         2'd0:    w_sign = w_shr[7];
         2'd1:    w_sign = w_shr[15];
         2'd2:    w_sign = w_shr[31];
         default: w_sign = 1'b0;
      endcase
      if (i_ext[2]) w_sign = 1'b0;
      o_rdata = (w_shr & w_lane) | (w_sign ? ~w_lane : '0);
   end

endmodule

// File: rtl/ysyx_23060061_lsu_hs.sv
// Multi-cycle load/store unit with valid/ready handshakes toward EXU, WBU and memory,
// including error detection and a response watchdog.
module ysyx_23060061_lsu_hs
   import ysyx_23060061_lsu_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_we,
   input  logic [2:0]      in_ext,
   input  logic [AW-1:0]   in_addr,
   input  logic [DW-1:0]   in_wdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_rdata,
   output logic [1:0]      out_err,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic            mem_req_we,
   output logic [AW-1:0]   mem_req_addr,
   output logic [DW-1:0]   mem_req_wdata,
   output logic [DW/8-1:0] mem_req_wmask,
   input  logic            mem_resp_valid,
   input  logic [DW-1:0]   mem_resp_rdata
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   lsu_state_e    r_state, w_state_nxt;
   logic          r_we, w_we_nxt;
   logic [2:0]    r_ext, w_ext_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [DW-1:0] r_wdata, w_wdata_nxt;
   logic [DW-1:0] r_rdata, w_rdata_nxt;
   logic [1:0]    r_err, w_err_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   logic          w_illegal;
   logic          w_misaligned;
   logic          w_timeout;
   logic [DW-1:0] w_load_data;
   logic [NB-1:0] w_wmask;
   logic [DW-1:0] w_lane_wdata;

   ysyx_23060061_lsu_align #(
      .DW (DW)
   ) u_align (
      .i_chk_we     (in_we),
      .i_chk_ext    (in_ext),
      .i_chk_off    (in_addr[OW-1:0]),
      .o_illegal    (w_illegal),
      .o_misaligned (w_misaligned),
      .i_we         (r_we),
      .i_ext        (r_ext),
      .i_off        (r_addr[OW-1:0]),
      .i_wdata      (r_wdata),
      .i_rdata      (mem_resp_rdata),
      .o_wmask      (w_wmask),
      .o_wdata      (w_lane_wdata),
      .o_rdata      (w_load_data)
   );

   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

   always_comb begin
      w_state_nxt = r_state;
      w_we_nxt    = r_we;
      w_ext_nxt   = r_ext;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_we_nxt    = in_we;
               w_ext_nxt   = in_ext;
               w_addr_nxt  = in_addr;
               w_wdata_nxt = in_wdata;
               w_rdata_nxt = '0;
               if (w_illegal) begin
                  w_state_nxt = StResp;
                  w_err_nxt   = ERR_ILLEGAL;
               end else if (w_misaligned) begin
                  w_state_nxt = StResp;
                  w_err_nxt   = ERR_MISALIGN;
               end else begin
                  w_state_nxt = StReq;
                  w_err_nxt   = ERR_OK;
               end
            end
         end
         StReq: begin
            if (mem_req_ready) begin
               w_state_nxt = StWait;
               w_cnt_nxt   = '0;
            end
         end
         StWait: begin
            // A response in the timeout cycle still wins.
            if (mem_resp_valid) begin
               w_state_nxt = StResp;
               w_err_nxt   = ERR_OK;
               w_rdata_nxt = r_we ? '0 : w_load_data;
            end else if (w_timeout) begin
               w_state_nxt = StResp;
               w_err_nxt   = ERR_TIMEOUT;
               w_rdata_nxt = '0;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StResp: begin
            if (out_ready) begin
               w_state_nxt = StIdle;
               w_rdata_nxt = '0;
               w_err_nxt   = ERR_OK;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_we    <= 1'b0;
         r_ext   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= ERR_OK;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_we_nxt;
         r_ext   <= w_ext_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign in_ready      = (r_state == StIdle);
   assign out_valid     = (r_state == StResp);
   assign out_rdata     = r_rdata;
   assign out_err       = r_err;
   assign mem_req_valid = (r_state == StReq);
   assign mem_req_we    = r_we;
   assign mem_req_addr  = {r_addr[AW-1:OW], {OW{1'b0}}};
   assign mem_req_wdata = w_lane_wdata;
   assign mem_req_wmask = w_wmask;

endmodule

// File: tb/tb_ysyx_23060061_lsu_hs.sv
// Scoreboard bench: stimulus pushes expected requests/responses, a negedge monitor
// checks them. DUT A is DW=32/TIMEOUT=4, DUT B is DW=64/default TIMEOUT; sel picks one.
module tb_ysyx_23060061_lsu_hs;
   import ysyx_23060061_lsu_pkg::*;

   localparam int BOUND = 60;

   typedef struct packed {
      logic [63:0] rdata;
      logic [1:0]  err;
      int          lat;
   } exp_out_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wmask;
      logic [63:0] wdata;
   } exp_req_t;

   logic        clk, rst, sel;
   logic        in_valid, in_we, out_ready, mem_req_ready, mem_resp_valid;
   logic [2:0]  in_ext;
   logic [31:0] in_addr;
   logic [63:0] in_wdata, mem_resp_rdata;

   logic        in_ready, out_valid, mem_req_valid, mem_req_we;
   logic [63:0] out_rdata, mem_req_wdata;
   logic [1:0]  out_err;
   logic [31:0] mem_req_addr;
   logic [7:0]  mem_req_wmask;

   logic        a_in_ready, a_out_valid, a_mem_req_valid, a_mem_req_we;
   logic [31:0] a_out_rdata, a_mem_req_addr, a_mem_req_wdata;
   logic [1:0]  a_out_err;
   logic [3:0]  a_mem_req_wmask;
   logic        b_in_ready, b_out_valid, b_mem_req_valid, b_mem_req_we;
   logic [63:0] b_out_rdata, b_mem_req_wdata;
   logic [31:0] b_mem_req_addr;
   logic [1:0]  b_out_err;
   logic [7:0]  b_mem_req_wmask;

   exp_out_t q_out[$];
   exp_req_t q_req[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_cyc = 0;
   bit lat_done = 1'b1;

   ysyx_23060061_lsu_hs #(.DW(32), .AW(32), .TIMEOUT(4)) u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_we(in_we), .in_ext(in_ext),
      .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
      .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_rdata(a_out_rdata),
      .out_err(a_out_err),
      .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready & ~sel),
      .mem_req_we(a_mem_req_we), .mem_req_addr(a_mem_req_addr),
      .mem_req_wdata(a_mem_req_wdata), .mem_req_wmask(a_mem_req_wmask),
      .mem_resp_valid(mem_resp_valid & ~sel), .mem_resp_rdata(mem_resp_rdata[31:0])
   );

   ysyx_23060061_lsu_hs #(.DW(64), .AW(32)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_we(in_we), .in_ext(in_ext),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_rdata(b_out_rdata),
      .out_err(b_out_err),
      .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready & sel),
      .mem_req_we(b_mem_req_we), .mem_req_addr(b_mem_req_addr),
      .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
      .mem_resp_valid(mem_resp_valid & sel), .mem_resp_rdata(mem_resp_rdata)
   );

   assign in_ready      = sel ? b_in_ready : a_in_ready;
   assign out_valid     = sel ? b_out_valid : a_out_valid;
   assign out_rdata     = sel ? b_out_rdata : {32'h0, a_out_rdata};
   assign out_err       = sel ? b_out_err : a_out_err;
   assign mem_req_valid = sel ? b_mem_req_valid : a_mem_req_valid;
   assign mem_req_we    = sel ? b_mem_req_we : a_mem_req_we;
   assign mem_req_addr  = sel ? b_mem_req_addr : a_mem_req_addr;
   assign mem_req_wdata = sel ? b_mem_req_wdata : {32'h0, a_mem_req_wdata};
   assign mem_req_wmask = sel ? b_mem_req_wmask : {4'h0, a_mem_req_wmask};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: time limit reached, required $finish before it");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL wait_%s: no event within %0d cycles, required it", name, BOUND);
   endtask

   function automatic bit sig(input int which);
      case (which)
         0:       return in_ready;
         1:       return mem_req_valid;
         default: return out_valid;
      endcase
   endfunction

   task automatic wait_sig(input int which, input string name);
      int n = 0;
      while (!sig(which) && n < BOUND) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= BOUND) fail_to(name);
   endtask

   // Monitor: compares whatever the DUT presents against the head of each queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            hs_cyc   = cyc;
            lat_done = 1'b0;
         end
         if (out_valid) begin
            chk("in_ready_in_resp", 64'(in_ready), 64'd0);
            if (q_out.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got out_valid with rdata %h err %0d, required none",
                        out_rdata, out_err);
            end else begin
               if (!lat_done) begin
                  lat_done = 1'b1;
                  if (q_out[0].lat >= 0) chk("latency", 64'(cyc - hs_cyc), 64'(q_out[0].lat));
               end
               chk("out_rdata", out_rdata, q_out[0].rdata);
               chk("out_err", 64'(out_err), 64'(q_out[0].err));
               if (out_ready) void'(q_out.pop_front());
            end
         end
         if (mem_req_valid) begin
            if (q_req.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_req: got request to %h, required none", mem_req_addr);
            end else begin
               chk("req_addr", 64'(mem_req_addr), 64'(q_req[0].addr));
               chk("req_we", 64'(mem_req_we), 64'(q_req[0].we));
               chk("req_wmask", 64'(mem_req_wmask), 64'(q_req[0].wmask));
               chk("req_wdata", mem_req_wdata, q_req[0].wdata);
               if (mem_req_ready) void'(q_req.pop_front());
            end
         end
      end
   end

   task automatic op(input logic we, input logic [2:0] ext, input logic [31:0] addr,
                     input logic [63:0] wdata, input bit has_req, input logic [31:0] maddr,
                     input logic [7:0] wmask, input logic [63:0] mwdata, input int req_stall,
                     input int resp_dly, input logic [63:0] resp_data, input int out_stall,
                     input logic [63:0] exp_rdata, input logic [1:0] exp_err, input int exp_lat);
      q_out.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
      if (has_req) q_req.push_back('{addr: maddr, we: we, wmask: wmask, wdata: mwdata});
      in_valid = 1'b1;
      in_we    = we;
      in_ext   = ext;
      in_addr  = addr;
      in_wdata = wdata;
      wait_sig(0, "in_ready");
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (has_req) begin
         wait_sig(1, "mem_req_valid");
         repeat (req_stall) begin @(posedge clk); #1; end
         mem_req_ready = 1'b1;
         @(posedge clk); #1;
         mem_req_ready = 1'b0;
         if (resp_dly > 0) begin
            repeat (resp_dly - 1) begin @(posedge clk); #1; end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = resp_data;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
         end
      end
      wait_sig(2, "out_valid");
      repeat (out_stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
      chk({tag, "_out_rdata"}, out_rdata, 64'd0);
      chk({tag, "_out_err"}, 64'(out_err), 64'd0);
   endtask

   initial begin
      sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_ext = '0; in_addr = '0;
      in_wdata = '0; out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      #1;
      chk_reset_outputs("rst_a");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Loads/stores with stalls on each side
      op(0, F3_B, 32'h8000_0003, 0, 1, 32'h8000_0000, 8'h00, 0, 0, 3, 64'h80FF_FFFF, 0,
         64'hFFFF_FF80, ERR_OK, 5);
      op(1, F3_H, 32'h8000_0002, 64'hBEEF, 1, 32'h8000_0000, 8'h0C, 64'hBEEF_0000, 2, 1,
         64'hDEAD_BEEF, 0, 64'h0, ERR_OK, 5);
      // Error cases: no memory request
      op(0, F3_W, 32'h8000_0006, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_MISALIGN, 1);
      op(0, 3'b111, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_ILLEGAL, 1);
      op(0, F3_D, 32'h8000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_ILLEGAL, 1);
      op(1, F3_BU, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_ILLEGAL, 1);
      op(1, F3_W, 32'h8000_0002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_MISALIGN, 1);
      op(0, F3_H, 32'h8000_0003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_MISALIGN, 1);
      // Watchdog, then a late response that must be ignored
      op(0, F3_W, 32'h8000_0010, 0, 1, 32'h8000_0010, 8'h00, 0, 0, 0, 0, 0,
         64'h0, ERR_TIMEOUT, 7);
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      op(0, F3_W, 32'h8000_0010, 0, 1, 32'h8000_0010, 8'h00, 0, 0, 1, 64'h1234_5678, 0,
         64'h1234_5678, ERR_OK, 3);
      op(0, F3_W, 32'h8000_0014, 0, 1, 32'h8000_0014, 8'h00, 0, 0, 5, 64'h0BAD_F00D, 0,
         64'h0BAD_F00D, ERR_OK, 7);
      // Long WBU backpressure then back-to-back loads
      op(0, F3_BU, 32'h8000_0001, 0, 1, 32'h8000_0000, 8'h00, 0, 0, 1, 64'h0000_FF00, 10,
         64'hFF, ERR_OK, 3);
      op(0, F3_HU, 32'h8000_0002, 0, 1, 32'h8000_0000, 8'h00, 0, 0, 1, 64'hABCD_0000, 0,
         64'hABCD, ERR_OK, 3);
      op(0, F3_H, 32'h8000_0002, 0, 1, 32'h8000_0000, 8'h00, 0, 0, 1, 64'hABCD_0000, 0,
         64'hFFFF_ABCD, ERR_OK, 3);
      op(1, F3_B, 32'h8000_0001, 64'h1234_56A5, 1, 32'h8000_0000, 8'h02, 64'h0000_A500, 0, 1,
         0, 0, 64'h0, ERR_OK, 3);
      op(1, F3_W, 32'h8000_0004, 64'hCAFE_F00D, 1, 32'h8000_0004, 8'h0F, 64'hCAFE_F00D, 1, 2,
         0, 0, 64'h0, ERR_OK, 5);

      // Asynchronous reset while waiting for memory
      q_req.push_back('{addr: 32'h8000_0020, we: 1'b0, wmask: 8'h00, wdata: 64'h0});
      in_valid = 1'b1; in_we = 1'b0; in_ext = F3_W; in_addr = 32'h8000_0020;
      wait_sig(0, "in_ready");
      @(posedge clk); #1;
      in_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_wait");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5555_5555;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      repeat (3) begin @(posedge clk); #1; end
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      op(0, F3_W, 32'h8000_0020, 0, 1, 32'h8000_0020, 8'h00, 0, 0, 1, 64'h0102_0304, 0,
         64'h0102_0304, ERR_OK, 3);

      // DW=64 unit
      sel = 1'b1;
      #1;
      op(0, F3_D, 32'h8000_0008, 0, 1, 32'h8000_0008, 8'h00, 0, 0, 2, 64'h1122_3344_5566_7788,
         0, 64'h1122_3344_5566_7788, ERR_OK, 4);
      op(0, F3_W, 32'h8000_000C, 0, 1, 32'h8000_0008, 8'h00, 0, 0, 1, 64'h8765_4321_0000_0000,
         0, 64'hFFFF_FFFF_8765_4321, ERR_OK, 3);
      op(0, F3_WU, 32'h8000_000C, 0, 1, 32'h8000_0008, 8'h00, 0, 0, 1, 64'h8765_4321_0000_0000,
         0, 64'h0000_0000_8765_4321, ERR_OK, 3);
      op(0, F3_B, 32'h8000_000F, 0, 1, 32'h8000_0008, 8'h00, 0, 0, 1, 64'h7F00_0000_0000_0000,
         0, 64'h7F, ERR_OK, 3);
      op(1, F3_D, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, 1, 32'h8000_0010, 8'hFF,
         64'h0123_4567_89AB_CDEF, 0, 1, 0, 0, 64'h0, ERR_OK, 3);
      op(1, F3_W, 32'h8000_0014, 64'hFFFF_FFFF_DEAD_BEEF, 1, 32'h8000_0010, 8'hF0,
         64'hDEAD_BEEF_0000_0000, 0, 1, 0, 0, 64'h0, ERR_OK, 3);
      op(1, F3_H, 32'h8000_0006, 64'h1234, 1, 32'h8000_0000, 8'hC0, 64'h1234_0000_0000_0000,
         0, 1, 0, 0, 64'h0, ERR_OK, 3);
      op(0, F3_D, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_MISALIGN, 1);
      op(1, F3_WU, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, ERR_ILLEGAL, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("q_out_drained", 64'(q_out.size()), 64'd0);
      chk("q_req_drained", 64'(q_req.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
